// File: rtl/bulk_in_axis_arbiter.sv
// Round-robin arbiter merging NUM_SRC byte-wide AXIS sources into one bulk IN stream.
// Define BULK_ARB_CHAN_TAG_EN to prefix every granted packet with a source-id header byte.
module bulk_in_axis_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int MAX_PKT = 512
) (
  input  logic                 axis_aclk,
  input  logic                 reset_n,
  input  logic [NUM_SRC-1:0]   s_axis_tvalid,
  output logic [NUM_SRC-1:0]   s_axis_tready,
  input  logic [8*NUM_SRC-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]   s_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic [NUM_SRC-1:0]   grant_o,
  output logic [1:0]           dbg_state
);

  // Handshake rule: a byte moves on a rising edge where tvalid and tready are
  // both high; tvalid/tdata/tlast then hold steady until that edge.

  localparam int IDX_W = $clog2(NUM_SRC);

`ifdef BULK_ARB_CHAN_TAG_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_DATA = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DATA = 2'd2} state_t;
`endif

  state_t             state;
  logic [IDX_W-1:0]   g_idx;
  logic [IDX_W-1:0]   last_grant;
  logic [10:0]        count;

  logic [IDX_W-1:0]   pick;
  logic [NUM_SRC-1:0] pick_oh;
  int                 cand;
  logic               src_valid;
  logic               src_last;
  logic [7:0]         src_byte;
  logic               at_max;

  assign dbg_state = state;
  assign at_max    = (count == 11'(MAX_PKT - 1));

  // Scan downward so the nearest valid source after last_grant is assigned last and wins.
  always_comb begin
    pick    = '0;
    pick_oh = '0;
    cand    = 0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = (int'(last_grant) + k) % NUM_SRC;
      if (s_axis_tvalid[IDX_W'(cand)]) begin
        pick    = IDX_W'(cand);
        pick_oh = NUM_SRC'(1) << cand;
      end
    end
  end

  always_comb begin
    src_valid = 1'b0;
    src_last  = 1'b0;
    src_byte  = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (g_idx == IDX_W'(i)) begin
        src_valid = s_axis_tvalid[i];
        src_last  = s_axis_tlast[i];
        src_byte  = s_axis_tdata[8*i +: 8];
      end
    end
  end

`ifdef BULK_ARB_CHAN_TAG_EN
  logic [2:0] g3;
  assign g3 = 3'(g_idx);
`endif

  // Data paths are pure muxes of the granted source so streaming adds no latency.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    case (state)
`ifdef BULK_ARB_CHAN_TAG_EN
      ST_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {5'b0, g3};
      end
`endif
      ST_DATA: begin
        m_axis_tvalid = src_valid;
        m_axis_tdata  = src_byte;
        m_axis_tlast  = src_last | at_max;
        s_axis_tready = grant_o & {NUM_SRC{m_axis_tready}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant_o    <= '0;
      g_idx      <= '0;
      last_grant <= IDX_W'(NUM_SRC - 1);
      count      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|s_axis_tvalid) begin
            g_idx   <= pick;
            grant_o <= pick_oh;
            count   <= '0;
`ifdef BULK_ARB_CHAN_TAG_EN
            state   <= ST_HDR;
`else
            state   <= ST_DATA;
`endif
          end
        end
`ifdef BULK_ARB_CHAN_TAG_EN
        ST_HDR: begin
          if (m_axis_tready) begin
            count <= count + 11'd1;
            state <= ST_DATA;
          end
        end
`endif
        ST_DATA: begin
          if (m_axis_tvalid && m_axis_tready) begin
            count <= count + 11'd1;
            if (m_axis_tlast) begin
              state      <= ST_IDLE;
              last_grant <= g_idx;
              grant_o    <= '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bulk_in_axis_arbiter.md
BULK_IN_AXIS_ARBITER -- requirements
Module: bulk_in_axis_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-002 Parameter NUM_SRC SHALL default to 4 and give the number of AXIS sources (2..8).
REQ-003 Parameter MAX_PKT SHALL default to 512 and give the maximum output packet length in bytes (2..1024).
REQ-004 Port axis_aclk, input, 1 bit: clock for all logic.
REQ-005 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port s_axis_tvalid, input, NUM_SRC bits: per-source valid.
REQ-007 Port s_axis_tready, output, NUM_SRC bits: per-source ready.
REQ-008 Port s_axis_tdata, input, 8*NUM_SRC bits: source i occupies bits [8i+7:8i].
REQ-009 Port s_axis_tlast, input, NUM_SRC bits: per-source end of packet.
REQ-010 Ports m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tdata (output, 8) and m_axis_tlast (output, 1) SHALL form the single stream towards the bulk IN endpoint FIFO.
REQ-011 Port grant_o, output, NUM_SRC bits: one-hot current owner, all zero when idle.

Function
REQ-012 The FSM SHALL have states IDLE, HDR and DATA; HDR exists only when the configuration macro is defined.
REQ-013 In IDLE with any s_axis_tvalid set, the FSM SHALL grant the first valid source searching upward, wrapping, from (last_grant+1) mod NUM_SRC.
REQ-014 It SHALL register grant_o and enter DATA (or HDR) on the next edge, so grant latency is 1 cycle.
REQ-015 In IDLE, m_axis_tvalid and all s_axis_tready SHALL be 0.
REQ-016 In DATA, m_axis_tvalid SHALL equal s_axis_tvalid[g], m_axis_tdata SHALL equal source g's byte, and s_axis_tready[g] SHALL equal m_axis_tready; all other readies SHALL be 0.
REQ-017 The DATA-state paths of REQ-016 SHALL be combinational, adding zero latency.
REQ-018 An 11-bit byte counter SHALL clear on grant and increment on each m_axis handshake.
REQ-019 m_axis_tlast SHALL be s_axis_tlast[g] OR (count == MAX_PKT-1).
REQ-020 A forced tlast SHALL split the source packet; the remainder re-arbitrates as a new packet.
REQ-021 A handshake with m_axis_tlast=1 SHALL return the FSM to IDLE, record last_grant=g and clear grant_o.
REQ-022 Back-to-back packets from one source SHALL each incur the 1 idle cycle.
REQ-023 m_axis_tvalid, once asserted, SHALL hold with data stable until the handshake (AXIS rule); the block SHALL NOT deassert it while the source holds valid.
REQ-024 Non-granted sources' valid changes SHALL have no effect until the next IDLE.

Reset
REQ-025 While reset_n=0: state=IDLE, grant_o=0, last_grant=NUM_SRC-1 (so source 0 wins first), counter=0, m_axis_tvalid=0, m_axis_tlast=0, all s_axis_tready=0.
REQ-026 Reset asserted mid-packet SHALL abort the packet immediately, with no tlast emitted.
REQ-027 Reset deassertion SHALL be treated as synchronous to axis_aclk; the first grant is possible on the second edge after release.

Configuration
REQ-028 Macro BULK_ARB_CHAN_TAG_EN, when defined, SHALL make each granted packet start with HDR.
REQ-029 HDR SHALL drive m_axis_tvalid=1, m_axis_tdata={5'b0, g[2:0]}, m_axis_tlast=0 and all s_axis_tready=0.
REQ-030 The HDR byte SHALL count toward MAX_PKT, and HDR SHALL go to DATA on handshake.
REQ-031 When BULK_ARB_CHAN_TAG_EN is undefined, the HDR state and its logic SHALL be absent and packets SHALL be byte-identical to source packets.

Verification
REQ-032 Sources 0 and 2 each hold a 3-byte packet, m_axis_tready=1 -> output source 0 bytes, 1 idle cycle, source 2 bytes; grant_o = 0001, 0000, 0100.
REQ-033 All 4 sources continuously valid with 1-byte packets -> grant order 0,1,2,3,0 with no starvation.
REQ-034 Source 1 sends a 1300-byte packet, MAX_PKT=512 -> three output packets of 512, 512 and 276 bytes, tlast on bytes 512, 1024 and 1300.
REQ-035 Random m_axis_tready throttling (50%) on a 10-byte packet -> byte sequence intact, tdata stable while tvalid&&!tready.
REQ-036 reset_n pulsed low after 5 of 10 bytes -> outputs zero within the reset cycle, no tlast; after release source 0 is granted first.
REQ-037 With BULK_ARB_CHAN_TAG_EN, source 3 sends bytes AA, BB -> output 03, AA, BB with tlast on BB.
